proc_sequencer: RTL and testbench

- Host-side sequencer that sits directly upstream of the processor core and drives its status, data_in and data_addr_in inputs.
- Each job runs in three phases: load bytes from a host stream into data memory, run the program until end_process, then read a result window back out of data memory onto a host stream.
- One job per start pulse; a single FSM with byte, address, latency and timeout counters.

---
 rtl/proc_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_proc_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_sequencer.sv
// Host-side sequencer for the processor core. For each job it streams bytes into
// data memory, lets the program run until end_process, then reads a result window back out.
module proc_sequencer #(
  parameter logic [15:0] LOAD_BASE   = 16'h0000,
  parameter logic [15:0] RESULT_BASE = 16'h0100,
  parameter int unsigned RESULT_LEN  = 16,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned RUN_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] load_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [1:0]  status,
  output logic [7:0]  data_in,
  output logic [15:0] data_addr_in,
  input  logic        end_process,
  input  logic [7:0]  dm_out,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam logic [1:0] ST_HOLD  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_READ  = 2'b11;

  localparam logic [15:0] LAST_IDX = 16'(RESULT_LEN - 1);
  localparam logic [15:0] LAT_LAST = 16'(READ_LAT - 1);
  localparam logic [15:0] RUN_LAST = 16'(RUN_TIMEOUT - 1);

  // S_RADDR waits out the memory latency; S_ROUT holds the captured byte for the host.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RADDR,
    S_ROUT,
    S_FIN
  } state_t;

  state_t      state, state_nx;
  logic [15:0] remaining, remaining_nx;
  logic [15:0] addr, addr_nx;
  logic [15:0] run_cnt, run_cnt_nx;
  logic [15:0] idx, idx_nx;
  logic [15:0] lat_cnt, lat_cnt_nx;
  logic        in_ready_nx;
  logic [1:0]  status_nx;
  logic [7:0]  data_in_nx;
  logic [15:0] data_addr_in_nx;
  logic        out_valid_nx;
  logic [7:0]  out_data_nx;
  logic        busy_nx;
  logic        done_nx;
  logic        timeout_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      addr         <= '0;
      run_cnt      <= '0;
      idx          <= '0;
      lat_cnt      <= '0;
      in_ready     <= 1'b0;
      status       <= ST_HOLD;
      data_in      <= '0;
      data_addr_in <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      remaining    <= remaining_nx;
      addr         <= addr_nx;
      run_cnt      <= run_cnt_nx;
      idx          <= idx_nx;
      lat_cnt      <= lat_cnt_nx;
      in_ready     <= in_ready_nx;
      status       <= status_nx;
      data_in      <= data_in_nx;
      data_addr_in <= data_addr_in_nx;
      out_valid    <= out_valid_nx;
      out_data     <= out_data_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      timeout      <= timeout_nx;
    end
  end

  // Every output is computed here as a next value so the register stage above is the only driver.
  always_comb begin
    state_nx        = state;
    remaining_nx    = remaining;
    addr_nx         = addr;
    run_cnt_nx      = run_cnt;
    idx_nx          = idx;
    lat_cnt_nx      = lat_cnt;
    in_ready_nx     = in_ready;
    status_nx       = status;
    data_in_nx      = data_in;
    data_addr_in_nx = data_addr_in;
    out_valid_nx    = out_valid;
    out_data_nx     = out_data;
    done_nx         = 1'b0;
    timeout_nx      = timeout;

    case (state)
      S_IDLE: begin
        status_nx    = ST_HOLD;
        in_ready_nx  = 1'b0;
        out_valid_nx = 1'b0;
        if (start) begin
          timeout_nx   = 1'b0;
          addr_nx      = LOAD_BASE;
          remaining_nx = load_count;
          if (load_count != 16'd0) begin
            state_nx    = S_LOAD;
            in_ready_nx = 1'b1;
          end else begin
            state_nx   = S_RUN;
            status_nx  = ST_RUN;
            run_cnt_nx = '0;
          end
        end
      end

      S_LOAD: begin
        // remaining==0 here means the last write cycle is on the bus; move on after it.
        if (remaining == 16'd0) begin
          state_nx   = S_RUN;
          status_nx  = ST_RUN;
          run_cnt_nx = '0;
        end else if (in_valid && in_ready) begin
          status_nx       = ST_WRITE;
          data_in_nx      = in_data;
          data_addr_in_nx = addr;
          addr_nx         = addr + 16'd1;
          remaining_nx    = remaining - 16'd1;
          if (remaining == 16'd1) in_ready_nx = 1'b0;
        end else begin
          status_nx = ST_HOLD;
        end
      end

      S_RUN: begin
        status_nx = ST_RUN;
        if (end_process) begin
          state_nx        = S_RADDR;
          status_nx       = ST_READ;
          idx_nx          = '0;
          data_addr_in_nx = RESULT_BASE;
          lat_cnt_nx      = '0;
        end else if (run_cnt == RUN_LAST) begin
          state_nx   = S_FIN;
          status_nx  = ST_HOLD;
          timeout_nx = 1'b1;
          done_nx    = 1'b1;
        end else begin
          run_cnt_nx = run_cnt + 16'd1;
        end
      end

      S_RADDR: begin
        if (lat_cnt == LAT_LAST) begin
          out_data_nx  = dm_out;
          out_valid_nx = 1'b1;
          state_nx     = S_ROUT;
        end else begin
          lat_cnt_nx = lat_cnt + 16'd1;
        end
      end

      S_ROUT: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          if (idx == LAST_IDX) begin
            state_nx  = S_FIN;
            status_nx = ST_HOLD;
            done_nx   = 1'b1;
          end else begin
            idx_nx          = idx + 16'd1;
            data_addr_in_nx = RESULT_BASE + idx + 16'd1;
            lat_cnt_nx      = '0;
            state_nx        = S_RADDR;
          end
        end
      end

      S_FIN: begin
        status_nx = ST_HOLD;
        state_nx  = S_IDLE;
      end

      default: begin
        state_nx  = S_IDLE;
        status_nx = ST_HOLD;
      end
    endcase

    busy_nx = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: a behavioural processor/memory model plus a negedge
// monitor; one linear initial block drives jobs and checks the logged activity.
`timescale 1ns/1ps
module tb_proc_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, end_process, out_ready;
  logic [15:0] load_count;
  logic [7:0]  in_data, dm_out;
  logic        in_ready, out_valid, busy, done, timeout;
  logic [1:0]  status;
  logic [7:0]  data_in, out_data;
  logic [15:0] data_addr_in;

  logic        w_in_ready, w_out_valid, w_busy, w_done, w_timeout;
  logic [1:0]  w_status;
  logic [7:0]  w_data_in, w_out_data;
  logic [15:0] w_data_addr_in;

  proc_sequencer #(
    .LOAD_BASE(16'h0000), .RESULT_BASE(16'h0100), .RESULT_LEN(16),
    .READ_LAT(2), .RUN_TIMEOUT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_count(load_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .status(status), .data_in(data_in), .data_addr_in(data_addr_in),
    .end_process(end_process), .dm_out(dm_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .timeout(timeout)
  );

  // Second instance with a load base near the top of memory to exercise address wrap.
  proc_sequencer #(
    .LOAD_BASE(16'hFFFE), .RESULT_BASE(16'h0100), .RESULT_LEN(16),
    .READ_LAT(2), .RUN_TIMEOUT(20)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .load_count(load_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .status(w_status), .data_in(w_data_in), .data_addr_in(w_data_addr_in),
    .end_process(end_process), .dm_out(dm_out),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(out_ready),
    .busy(w_busy), .done(w_done), .timeout(w_timeout)
  );

  // ---------------- processor / memory model ----------------
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (a >= 16'h0100 && a < 16'h0110) return 8'h10 + a[7:0];
    return 8'h5A;
  endfunction

  // Two-cycle read: the address registered at edge A yields data sampled at edge A+2.
  logic [7:0] dm_q = 8'hEE;
  always @(posedge clk) dm_q <= (status == 2'b11) ? mem_rd(data_addr_in) : 8'hEE;
  assign dm_out = dm_q;

  bit ep_en;
  int ep_at;
  int run_cycles;
  assign end_process = ep_en && (run_cycles == ep_at);

  // ---------------- monitor ----------------
  int          cyc, rd_cycles, acc_cnt, inr_cnt, done_cnt, bad_wr, stab_err, dbl_done;
  logic [23:0] wr_log[$];
  logic [23:0] w_wr_log[$];
  int          wr_cyc[$];
  logic [7:0]  out_log[$];
  logic        prev_xfer, prev_ov, prev_hs, prev_done;
  logic [7:0]  prev_od;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (status == 2'b10) begin
        wr_log.push_back({data_addr_in, data_in});
        wr_cyc.push_back(cyc);
        if (!prev_xfer) bad_wr++;
      end
      if (w_status == 2'b10) w_wr_log.push_back({w_data_addr_in, w_data_in});
      if (status == 2'b01) run_cycles++;
      if (status == 2'b11) rd_cycles++;
      if (in_ready) inr_cnt++;
      if (in_valid && in_ready) acc_cnt++;
      if (done) begin
        done_cnt++;
        if (prev_done) dbl_done++;
      end
      if (prev_ov && !prev_hs && (!out_valid || out_data !== prev_od)) stab_err++;
      if (out_valid && out_ready) out_log.push_back(out_data);
    end
    prev_xfer = in_valid && in_ready;
    prev_ov   = out_valid;
    prev_hs   = out_valid && out_ready;
    prev_od   = out_data;
    prev_done = done;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  logic [7:0] bytes[$];
  bit   tog_mode, bp_mode, in_always, tog_ph, poked;
  int   stall;
  logic [1:0] st_after_start;
  logic       to_after_start;

  task automatic clear_logs();
    wr_log.delete(); w_wr_log.delete(); wr_cyc.delete(); out_log.delete();
    run_cycles = 0; rd_cycles = 0; acc_cnt = 0; inr_cnt = 0; done_cnt = 0;
    bad_wr = 0; stab_err = 0; dbl_done = 0; stall = 0; poked = 0;
  endtask

  task automatic drive_inputs();
    tog_ph = ~tog_ph;
    in_valid = in_always || ((acc_cnt < bytes.size()) && (!tog_mode || tog_ph));
    in_data  = (acc_cnt < bytes.size()) ? bytes[acc_cnt] : 8'h77;
    if (bp_mode && out_valid && out_log.size() == 3 && stall < 5) begin
      out_ready = 1'b0;
      stall++;
    end else begin
      out_ready = 1'b1;
    end
  endtask

  task automatic run_job(input logic [15:0] cnt, input bit tog, input bit bp,
                         input bit epe, input int epa, input bit poke, input bit in_alw);
    clear_logs();
    tog_mode = tog; bp_mode = bp; in_always = in_alw;
    ep_en = epe; ep_at = epa;
    @(posedge clk); #1;
    start = 1'b1; load_count = cnt;
    drive_inputs();
    @(posedge clk); #1;
    start = 1'b0;
    st_after_start = status;
    to_after_start = timeout;
    drive_inputs();
    for (int k = 0; k < 600 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      if (poke && !poked && status == 2'b01) begin
        start = 1'b1; load_count = 16'd5; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      drive_inputs();
    end
    in_always = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive_inputs();
    end
    check("job_done_count", done_cnt, 1);
    check("job_busy_idle", busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; load_count = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; ep_en = 1'b0; ep_at = 0; tog_ph = 1'b0;
    clear_logs();
    #23;
    check("rst_status", status, 2'b00);
    check("rst_ctl", {in_ready, out_valid, busy, done, timeout}, 5'b0);
    check("rst_data", {data_in, data_addr_in, out_data}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic job
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_job(16'd4, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0);
    check("basic_wr_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("basic_wr%0d", i), wr_log[i], {16'(i), bytes[i]});
    check("basic_wr_back_to_back", wr_cyc[3] - wr_cyc[0], 3);
    check("basic_after_start_load", st_after_start, 2'b00);
    check("basic_run_cycles", run_cycles, 10);
    check("basic_rd_cycles", rd_cycles, 48);
    check("basic_out_count", out_log.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("basic_out%0d", i), out_log[i], 8'h10 + 8'(i));
    check("basic_timeout", timeout, 1'b0);
    check("basic_single_done", dbl_done, 0);
    check("basic_wrap_count", w_wr_log.size(), 4);

    // Backpressure on both streams
    bytes = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    run_job(16'd4, 1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0);
    check("bp_wr_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_wr%0d", i), wr_log[i], {16'(i), bytes[i]});
    check("bp_write_after_xfer", bad_wr, 0);
    check("bp_out_stable", stab_err, 0);
    check("bp_out_count", out_log.size(), 16);
    check("bp_out3", out_log[3], 8'h13);
    check("bp_out15", out_log[15], 8'h1F);
    check("bp_rd_cycles", rd_cycles, 53);

    // Zero-length load, host keeps in_valid high throughout
    bytes = '{};
    run_job(16'd0, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1);
    check("zero_after_start_run", st_after_start, 2'b01);
    check("zero_no_writes", wr_log.size(), 0);
    check("zero_in_ready_low", inr_cnt, 0);
    check("zero_run_cycles", run_cycles, 6);
    check("zero_out_count", out_log.size(), 16);

    // Run timeout
    bytes = '{8'h5C};
    run_job(16'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("to_wr", wr_log[0], {16'h0000, 8'h5C});
    check("to_run_cycles", run_cycles, 20);
    check("to_flag", timeout, 1'b1);
    check("to_no_read", rd_cycles, 0);
    check("to_no_out", out_log.size(), 0);

    // end_process on the timeout cycle, with a start pulse during RUN
    bytes = '{};
    run_job(16'd0, 1'b0, 1'b0, 1'b1, 20, 1'b1, 1'b0);
    check("coll_start_clears_to", to_after_start, 1'b0);
    check("coll_run_cycles", run_cycles, 20);
    check("coll_timeout_low", timeout, 1'b0);
    check("coll_rd_cycles", rd_cycles, 48);
    check("coll_out_count", out_log.size(), 16);
    repeat (5) @(posedge clk);
    #1;
    check("coll_start_ignored", done_cnt, 1);
    check("coll_stays_idle", busy, 1'b0);

    // Reset in the middle of READ
    clear_logs();
    bytes = '{8'h01, 8'h02};
    tog_mode = 1'b0; bp_mode = 1'b0; in_always = 1'b0; ep_en = 1'b1; ep_at = 3;
    @(posedge clk); #1;
    start = 1'b1; load_count = 16'd2;
    drive_inputs();
    @(posedge clk); #1;
    start = 1'b0;
    drive_inputs();
    for (int k = 0; k < 200 && status != 2'b11; k++) begin
      @(posedge clk); #1;
      drive_inputs();
    end
    check("mid_reached_read", status, 2'b11);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_status", status, 2'b00);
    check("mid_rst_ctl", {in_ready, out_valid, busy, done, timeout}, 5'b0);
    check("mid_rst_data", {data_in, data_addr_in, out_data}, 32'h0);
    check("mid_rst_wrap", {w_status, w_busy, w_out_valid, w_data_addr_in}, 20'h0);
    repeat (3) @(posedge clk);
    #2;
    check("mid_rst_no_done", done_cnt, 0);
    rst_n = 1'b1;

    // Clean job after reset; the wrap instance writes FFFE, FFFF, 0000
    bytes = '{8'h11, 8'h22, 8'h33};
    run_job(16'd3, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    check("post_wr_count", wr_log.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("post_wr%0d", i), wr_log[i], {16'(i), bytes[i]});
    for (int i = 0; i < 3; i++) begin
      logic [15:0] a;
      a = 16'hFFFE + 16'(i);
      check($sformatf("wrap_wr%0d", i), w_wr_log[i], {a, bytes[i]});
    end
    check("post_out_count", out_log.size(), 16);
    check("post_out15", out_log[15], 8'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
